// File: rtl/rep_data2stream_n.sv
// rep_data2stream_n: pops {data, operand} entries from a show-ahead FIFO and
// expands each into a packet of operand+1 beats spread over LANES parallel
// Avalon-ST lanes. Beats are consumed in prefix order (lane 0 upward), packets
// run back-to-back without a bubble, and completed packets are counted.
module rep_data2stream_n #(
   parameter int DATA_W   = 8,
   parameter int OPER_W   = 4,
   parameter int LANES    = 4,
   parameter int INC_MODE = 0,
   parameter int CNT_W    = 16
) (
   input  logic                      clk_i,
   input  logic                      nrst_i,
   input  logic                      fifo_empty_i,
   input  logic [DATA_W-1:0]         fifo_data_i,
   input  logic [OPER_W-1:0]         fifo_operand_i,
   output logic                      fifo_rd_o,
   input  logic [LANES-1:0]          src_rdy_i,
   output logic [LANES*DATA_W-1:0]   src_data_o,
   output logic [LANES-1:0]          src_vd_o,
   output logic [LANES-1:0]          src_sop_o,
   output logic [LANES-1:0]          src_eop_o,
   output logic                      busy_o,
   output logic [CNT_W-1:0]          pkt_cnt_o
);

   localparam int RW = OPER_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   base_q, base_d;
   logic [RW-1:0]       rem_q, rem_d;
   logic [RW-1:0]       idx_q, idx_d;
   logic                first_q, first_d;
   logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

   logic [LANES-1:0]        vd;
   logic [LANES-1:0]        sop;
   logic [LANES-1:0]        eop;
   logic [LANES*DATA_W-1:0] data;
   logic [RW-1:0]           acc;
   logic                    pop;

   // Lane outputs derived from registers only, so ready never feeds valid.
   always_comb begin
      logic [31:0] lane_sum;
      vd       = '0;
      sop      = '0;
      eop      = '0;
      data     = '0;
      lane_sum = '0;
      if (state_q == SEND) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            vd[i]  = (32'(rem_q) > i);
            eop[i] = (32'(rem_q) == (i + 1));
            if (INC_MODE != 0)
               lane_sum = 32'(base_q) + 32'(idx_q) + i;
            else
               lane_sum = 32'(base_q);
            data[i*DATA_W +: DATA_W] = lane_sum[DATA_W-1:0];
         end
         sop[0] = first_q;
      end
   end

   // Accepted beat count: contiguous run of valid&ready lanes from lane 0.
   always_comb begin
      int unsigned acc_cnt;
      logic        run;
      acc_cnt = 0;
      run     = 1'b1;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (run && vd[i] && src_rdy_i[i])
            acc_cnt = acc_cnt + 1;
         else
            run = 1'b0;
      end
      acc = RW'(acc_cnt);
   end

   // Next-state: load on pop, advance on acceptance, chain packets on completion.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      rem_d     = rem_q;
      idx_d     = idx_q;
      first_d   = first_q;
      pkt_cnt_d = pkt_cnt_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty_i) begin
               pop     = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (acc != '0) begin
               rem_d   = rem_q - acc;
               idx_d   = idx_q + acc;
               first_d = 1'b0;
               if (acc == rem_q) begin
                  pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                  if (!fifo_empty_i)
                     pop = 1'b1;
                  else
                     state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A pop overrides the advance above so the next packet starts zero-bubble.
      if (pop) begin
         base_d  = fifo_data_i;
         rem_d   = RW'(fifo_operand_i) + RW'(1);
         idx_d   = '0;
         first_d = 1'b1;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         state_q   <= IDLE;
         base_q    <= '0;
         rem_q     <= '0;
         idx_q     <= '0;
         first_q   <= 1'b0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         rem_q     <= rem_d;
         idx_q     <= idx_d;
         first_q   <= first_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   // No pop while reset is held, so no FIFO entry is consumed and lost.
   assign fifo_rd_o  = pop & nrst_i;
   assign src_vd_o   = vd;
   assign src_sop_o  = sop;
   assign src_eop_o  = eop;
   assign src_data_o = data;
   assign busy_o     = (state_q == SEND);
   assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_rep_data2stream_n.sv
// Directed bench for rep_data2stream_n: one replicate-mode and one
// incrementing-mode instance share the FIFO model and lane-ready stimulus.
module tb_rep_data2stream_n;

   logic        clk;
   logic        nrst;
   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic [3:0]  fifo_operand;
   logic [3:0]  rdy;

   logic        rd_a, rd_b;
   logic [31:0] data_a, data_b;
   logic [3:0]  vd_a, vd_b, sop_a, sop_b, eop_a, eop_b;
   logic        busy_a, busy_b;
   logic [15:0] cnt_a, cnt_b;

   typedef struct packed {
      logic [7:0] d;
      logic [3:0] o;
   } ent_t;
   ent_t fq[$];

   int n_chk = 0;
   int n_err = 0;

   rep_data2stream_n #(.DATA_W(8), .OPER_W(4), .LANES(4), .INC_MODE(0), .CNT_W(16)) u_dut (
      .clk_i(clk), .nrst_i(nrst), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
      .fifo_operand_i(fifo_operand), .fifo_rd_o(rd_a), .src_rdy_i(rdy), .src_data_o(data_a),
      .src_vd_o(vd_a), .src_sop_o(sop_a), .src_eop_o(eop_a), .busy_o(busy_a), .pkt_cnt_o(cnt_a)
   );

   rep_data2stream_n #(.DATA_W(8), .OPER_W(4), .LANES(4), .INC_MODE(1), .CNT_W(16)) u_dut_inc (
      .clk_i(clk), .nrst_i(nrst), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
      .fifo_operand_i(fifo_operand), .fifo_rd_o(rd_b), .src_rdy_i(rdy), .src_data_o(data_b),
      .src_vd_o(vd_b), .src_sop_o(sop_b), .src_eop_o(eop_b), .busy_o(busy_b), .pkt_cnt_o(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive_fifo();
      if (fq.size() > 0) begin
         fifo_empty   = 1'b0;
         fifo_data    = fq[0].d;
         fifo_operand = fq[0].o;
      end else begin
         fifo_empty   = 1'b1;
         fifo_data    = '0;
         fifo_operand = '0;
      end
   endtask

   task automatic push(input logic [7:0] d, input logic [3:0] o);
      fq.push_back('{d: d, o: o});
      drive_fifo();
      #1;
   endtask

   // One clock: honour the pop seen before the edge, then refresh FIFO pins.
   task automatic step();
      logic pop;
      pop = rd_a;
      @(posedge clk);
      #1;
      if (pop && fq.size() > 0) void'(fq.pop_front());
      drive_fifo();
      #1;
   endtask

   initial begin
      logic [3:0]  hv, he, hs;
      logic [31:0] hd;
      int          rem_m, idx_m, beats, sops, eops, acc;
      logic [3:0]  exp_vd, exp_eop, exp_sop;
      logic [31:0] exp_inc, mask;
      logic        run;

      nrst = 1'b0;
      rdy  = 4'b1111;
      drive_fifo();
      step();
      step();
      chk("rst_vd", vd_a, 4'b0000);
      chk("rst_sop", sop_a, 4'b0000);
      chk("rst_eop", eop_a, 4'b0000);
      chk("rst_data", data_a, 32'h0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_cnt", cnt_a, 16'd0);
      chk("rst_rd", rd_a, 1'b0);
      nrst = 1'b1;
      step();

      // {A5, op 5}: 6 beats over two cycles
      push(8'hA5, 4'd5);
      chk("t1_rd0", rd_a, 1'b1);
      chk("t1_vd0", vd_a, 4'b0000);
      step();
      chk("t1_vd1", vd_a, 4'b1111);
      chk("t1_data1", data_a, 32'hA5A5A5A5);
      chk("t1_sop1", sop_a, 4'b0001);
      chk("t1_eop1", eop_a, 4'b0000);
      chk("t1_busy1", busy_a, 1'b1);
      chk("t1_rd1", rd_a, 1'b0);
      step();
      chk("t1_vd2", vd_a, 4'b0011);
      chk("t1_eop2", eop_a, 4'b0010);
      chk("t1_sop2", sop_a, 4'b0000);
      chk("t1_data2", data_a & 32'h0000FFFF, 32'h0000A5A5);
      step();
      chk("t1_busy3", busy_a, 1'b0);
      chk("t1_vd3", vd_a, 4'b0000);
      chk("t1_cnt", cnt_a, 16'd1);

      // {FE, op 6}: incrementing data wraps past FF
      push(8'hFE, 4'd6);
      step();
      chk("t2_inc_data1", data_b, 32'h0100FFFE);
      chk("t2_inc_vd1", vd_b, 4'b1111);
      chk("t2_inc_sop1", sop_b, 4'b0001);
      step();
      chk("t2_inc_vd2", vd_b, 4'b0111);
      chk("t2_inc_eop2", eop_b, 4'b0100);
      chk("t2_inc_data2", data_b & 32'h00FFFFFF, 32'h00040302);
      step();
      chk("t2_cnt_a", cnt_a, 16'd2);
      chk("t2_cnt_b", cnt_b, 16'd2);

      // two queued entries, back-to-back without a bubble
      push(8'h11, 4'd3);
      push(8'h22, 4'd0);
      chk("t3_rd0", rd_a, 1'b1);
      step();
      chk("t3_vd1", vd_a, 4'b1111);
      chk("t3_eop1", eop_a, 4'b1000);
      chk("t3_data1", data_a, 32'h11111111);
      chk("t3_rd1", rd_a, 1'b1);
      step();
      chk("t3_vd2", vd_a, 4'b0001);
      chk("t3_sop2", sop_a, 4'b0001);
      chk("t3_eop2", eop_a, 4'b0001);
      chk("t3_data2", data_a & 32'h000000FF, 32'h00000022);
      chk("t3_busy2", busy_a, 1'b1);
      chk("t3_rd2", rd_a, 1'b0);
      step();
      chk("t3_busy3", busy_a, 1'b0);
      chk("t3_cnt", cnt_a, 16'd4);

      // partial ready 1011: only lanes 0..1 consumed
      rdy = 4'b1011;
      push(8'h33, 4'd3);
      step();
      chk("t4_vd1", vd_a, 4'b1111);
      chk("t4_sop1", sop_a, 4'b0001);
      chk("t4_eop1", eop_a, 4'b1000);
      step();
      chk("t4_vd2", vd_a, 4'b0011);
      chk("t4_sop2", sop_a, 4'b0000);
      chk("t4_eop2", eop_a, 4'b0010);
      chk("t4_data2", data_a & 32'h0000FFFF, 32'h00003333);
      chk("t4_inc_data2", data_b & 32'h0000FFFF, 32'h00003635);
      hv = vd_a; he = eop_a; hs = sop_a; hd = data_b;
      rdy = 4'b0000;
      step();
      chk("t4_hold_vd", vd_a, hv);
      chk("t4_hold_eop", eop_a, he);
      chk("t4_hold_sop", sop_a, hs);
      chk("t4_hold_data", data_b, hd);
      chk("t4_hold_rd", rd_a, 1'b0);
      rdy = 4'b0010;
      step();
      chk("t4_hold2_vd", vd_a, 4'b0011);
      chk("t4_hold2_data", data_b, hd);
      rdy = 4'b1111;
      step();
      chk("t4_busy", busy_a, 1'b0);
      chk("t4_cnt", cnt_a, 16'd5);

      // operand all-ones: 16 beats under random ready, model-tracked
      push(8'hF8, 4'd15);
      step();
      rem_m = 16; idx_m = 0; beats = 0; sops = 0; eops = 0;
      for (int cyc = 0; cyc < 200 && rem_m > 0; cyc++) begin
         exp_vd = '0; exp_eop = '0; exp_inc = '0; mask = '0;
         for (int i = 0; i < 4; i++) begin
            exp_vd[i]  = (rem_m > i);
            exp_eop[i] = (rem_m == i + 1);
            if (rem_m > i) begin
               mask[i*8 +: 8]    = 8'hFF;
               exp_inc[i*8 +: 8] = 8'(8'hF8 + idx_m + i);
            end
         end
         exp_sop = {3'b000, (idx_m == 0)};
         chk("t5_vd", vd_a, exp_vd);
         chk("t5_eop", eop_b, exp_eop);
         chk("t5_sop", sop_b, exp_sop);
         chk("t5_inc_data", data_b & mask, exp_inc);
         chk("t5_data", data_a & mask, 32'hF8F8F8F8 & mask);
         rdy = 4'($urandom_range(0, 15));
         acc = 0; run = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (run && vd_a[i] && rdy[i]) begin
               acc++;
               beats++;
               if (sop_a[i]) sops++;
               if (eop_a[i]) eops++;
            end else begin
               run = 1'b0;
            end
         end
         step();
         rem_m = rem_m - acc;
         idx_m = idx_m + acc;
      end
      chk("t5_remaining", 64'(rem_m), 64'd0);
      chk("t5_beats", 64'(beats), 64'd16);
      chk("t5_sops", 64'(sops), 64'd1);
      chk("t5_eops", 64'(eops), 64'd1);
      chk("t5_busy", busy_a, 1'b0);
      chk("t5_cnt", cnt_a, 16'd6);

      // reset mid-packet, then a clean restart
      rdy = 4'b1111;
      push(8'h44, 4'd7);
      step();
      chk("t6_vd1", vd_a, 4'b1111);
      push(8'h55, 4'd2);
      nrst = 1'b0;
      step();
      chk("t6_rst_vd", vd_a, 4'b0000);
      chk("t6_rst_sop", sop_a, 4'b0000);
      chk("t6_rst_eop", eop_a, 4'b0000);
      chk("t6_rst_data", data_a, 32'h0);
      chk("t6_rst_busy", busy_a, 1'b0);
      chk("t6_rst_cnt", cnt_a, 16'd0);
      chk("t6_rst_rd", rd_a, 1'b0);
      nrst = 1'b1;
      #1;
      chk("t6_rd0", rd_a, 1'b1);
      step();
      chk("t6_vd", vd_a, 4'b0111);
      chk("t6_sop", sop_a, 4'b0001);
      chk("t6_eop", eop_a, 4'b0100);
      chk("t6_data", data_a & 32'h00FFFFFF, 32'h00555555);
      chk("t6_cnt0", cnt_a, 16'd0);
      step();
      chk("t6_cnt1", cnt_a, 16'd1);
      chk("t6_busy", busy_a, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
